ofifo_param: RTL and testbench

// - Output FIFO behind the PE array: one independent FIFO lane per array column.
// - Each lane is written by its own column strobe. Results leave the array skewed, so columns arrive on different cycles.
// - A row is popped from all lanes together once every lane holds data. The popped row goes to SRAM write-back.
// - Successor to the fixed single-entry ofifo. Adds parametrised depth, per-lane occupancy, a row-level count and overflow/underflow handling.

---
 rtl/ofifo_pkg.sv | 14 +
 rtl/ofifo_param_if.sv | 44 ++++
 rtl/ofifo_lane.sv | 58 +++++
 rtl/ofifo_param.sv | 91 +++++++++
 tb/tb_ofifo_param.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ofifo_pkg.sv
// Shared constants for the PE-array FIFOs (ififo / ofifo / core) and the
// pointer-width helper used to size lane pointers and occupancy counters.
package ofifo_pkg;

    localparam int COL_DEF   = 8;
    localparam int BW_DEF    = 4;
    localparam int DEPTH_DEF = 64;

    // Pointer width for a power-of-two depth; counters are one bit wider.
    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ofifo_param_if.sv
// Row/lane bus between the PE array side and the output FIFO.
// Optional error-flag signals exist only when OFIFO_ERR_EN is defined.
interface ofifo_param_if
    import ofifo_pkg::*;
#(
    parameter int col   = COL_DEF,
    parameter int bw    = BW_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int AW = calc_aw(DEPTH);

    logic [col-1:0]    wr;
    logic [col*bw-1:0] in;
    logic              rd;
    logic [col*bw-1:0] out;
    logic              o_full;
    logic              o_ready;
    logic              o_valid;
    logic [AW:0]       o_rows;
`ifdef OFIFO_ERR_EN
    logic [col-1:0]    o_ovf;
    logic              o_udf;
    logic              err_clr;

    modport master (
        output wr, in, rd, err_clr,
        input  out, o_full, o_ready, o_valid, o_rows, o_ovf, o_udf
    );
    modport slave (
        input  wr, in, rd, err_clr,
        output out, o_full, o_ready, o_valid, o_rows, o_ovf, o_udf
    );
`else
    modport master (
        output wr, in, rd,
        input  out, o_full, o_ready, o_valid, o_rows
    );
    modport slave (
        input  wr, in, rd,
        output out, o_full, o_ready, o_valid, o_rows
    );
`endif

endinterface

// File: rtl/ofifo_lane.sv
// One column lane of the output FIFO: circular buffer with read/write
// pointers and an occupancy counter. The read side is fall-through: dout is
// the entry at rptr with no latency. pop arrives already qualified, so it is
// never asserted on an empty lane.
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int   bw    = BW_DEF,
    parameter int   DEPTH = DEPTH_DEF,
    localparam int  AW    = calc_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          pop,
    input  logic [bw-1:0] din,
    output logic [bw-1:0] dout,
    output logic [AW:0]   cnt
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [bw-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_ok;

    // A full lane still takes a write when the same edge pops a slot free.
    assign wr_ok = wr && ((cnt != FULL_CNT) || pop);
    assign dout  = mem[rptr];

    // Storage, pointer and occupancy update; reset clears the memory so the
    // head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ofifo_param.sv
// Output FIFO behind the PE array: col independent lanes written by skewed
// column strobes, popped together as a row once every lane holds data.
// Build option: define OFIFO_ERR_EN for sticky overflow/underflow flags.
module ofifo_param
    import ofifo_pkg::*;
#(
    parameter int col   = COL_DEF,
    parameter int bw    = BW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    ofifo_param_if.slave  bus
);

    localparam int          AW       = calc_aw(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0] cnt [col];
    logic        pop;
    logic        full_any;
    logic        valid_all;
    logic [AW:0] rows_min;

    // A row pop is only honoured when a complete row sits at the head.
    assign pop = bus.rd & valid_all;

    for (genvar c = 0; c < col; c++) begin : g_lane
        ofifo_lane #(
            .bw    (bw),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (bus.wr[c]),
            .pop   (pop),
            .din   (bus.in[c*bw +: bw]),
            .dout  (bus.out[c*bw +: bw]),
            .cnt   (cnt[c])
        );
    end

    // Row-level status reduced from the per-lane occupancy counters.
    always_comb begin
        full_any  = 1'b0;
        valid_all = 1'b1;
        rows_min  = FULL_CNT;
        for (int c = 0; c < col; c++) begin
            if (cnt[c] == FULL_CNT) full_any  = 1'b1;
            if (cnt[c] == '0)       valid_all = 1'b0;
            if (cnt[c] < rows_min)  rows_min  = cnt[c];
        end
    end

    assign bus.o_full  = full_any;
    assign bus.o_ready = ~full_any;
    assign bus.o_valid = valid_all;
    assign bus.o_rows  = rows_min;

`ifdef OFIFO_ERR_EN
    logic [col-1:0] ovf_set;
    logic [col-1:0] ovf_q;
    logic           udf_set;
    logic           udf_q;

    // A write is dropped when its lane is full and no row pop frees a slot.
    always_comb begin
        ovf_set = '0;
        for (int c = 0; c < col; c++) begin
            ovf_set[c] = bus.wr[c] && (cnt[c] == FULL_CNT) && !pop;
        end
    end

    assign udf_set = bus.rd & ~valid_all;

    // Sticky error flags; a new error in the clear cycle keeps its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= (bus.err_clr ? '0 : ovf_q) | ovf_set;
            udf_q <= (bus.err_clr ? 1'b0 : udf_q) | udf_set;
        end
    end

    assign bus.o_ovf = ovf_q;
    assign bus.o_udf = udf_q;
`endif

endmodule

// File: tb/tb_ofifo_param.sv
// Bench for ofifo_param (col=8, bw=4, DEPTH=4): queue-per-lane reference
// model with an every-cycle compare, directed scenarios with literal values,
// then a randomized phase. Works with or without OFIFO_ERR_EN.
module tb_ofifo_param;

    localparam int COL   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic clr;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    ofifo_param_if #(.col(COL), .bw(BW), .DEPTH(DEPTH)) bus ();

    ofifo_param #(.col(COL), .bw(BW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef OFIFO_ERR_EN
    assign bus.err_clr = clr;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per lane, updated at each rising edge.
    logic [BW-1:0] mq [COL][$];
    logic [COL-1:0] m_ovf;
    logic           m_udf;

    always @(posedge clk) begin
        bit m_valid;
        bit m_pop;
        bit was_full;
        logic [COL-1:0] nov;
        if (reset) begin
            for (int c = 0; c < COL; c++) mq[c].delete();
            m_ovf = '0;
            m_udf = 1'b0;
        end else begin
            m_valid = 1'b1;
            for (int c = 0; c < COL; c++) if (mq[c].size() == 0) m_valid = 1'b0;
            m_pop = bus.rd && m_valid;
            nov = '0;
            for (int c = 0; c < COL; c++) begin
                was_full = (mq[c].size() == DEPTH);
                if (m_pop) void'(mq[c].pop_front());
                if (bus.wr[c]) begin
                    if (!was_full || m_pop) mq[c].push_back(bus.in[c*BW +: BW]);
                    else nov[c] = 1'b1;
                end
            end
            if (clr) begin
                m_ovf = '0;
                m_udf = 1'b0;
            end
            m_ovf = m_ovf | nov;
            m_udf = m_udf | (bus.rd && !m_valid);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        int          mn;
        bit          e_valid;
        bit          e_full;
        logic [31:0] e_out;
        if (chk_en) begin
            mn = DEPTH;
            e_full = 1'b0;
            e_out = '0;
            for (int c = 0; c < COL; c++) begin
                if (mq[c].size() < mn) mn = mq[c].size();
                if (mq[c].size() == DEPTH) e_full = 1'b1;
            end
            e_valid = (mn != 0);
            if (e_valid) for (int c = 0; c < COL; c++) e_out[c*BW +: BW] = mq[c][0];
            chk("m_valid", 32'(bus.o_valid), 32'(e_valid));
            chk("m_full",  32'(bus.o_full),  32'(e_full));
            chk("m_ready", 32'(bus.o_ready), 32'(!e_full));
            chk("m_rows",  32'(bus.o_rows),  32'(mn));
            if (e_valid) chk("m_out", bus.out, e_out);
`ifdef OFIFO_ERR_EN
            chk("m_ovf", 32'(bus.o_ovf), 32'(m_ovf));
            chk("m_udf", 32'(bus.o_udf), 32'(m_udf));
`endif
        end
    end

    task automatic step(input logic [7:0] w, input logic [31:0] d, input logic r);
        bus.wr = w;
        bus.in = d;
        bus.rd = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rows [4];
        logic [31:0] v [10];
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rows [4];
        logic [31:0] v [10];
        logic [7:0]  w;
        reset = 1'b1;
        clr   = 1'b0;
        bus.wr = '0;
        bus.in = '0;
        bus.rd = 1'b0;
        step(8'h00, 32'h0, 1'b0);
        step(8'h00, 32'h0, 1'b0);
        reset = 1'b0;
        chk_en = 1;

        // Reset state
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_full",  32'(bus.o_full),  32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_rows",  32'(bus.o_rows),  32'd0);
        chk("rst_out",   bus.out,          32'h0);

        // Skewed fill: lane c gets c+1 on cycle c
        for (int c = 0; c < COL; c++) begin
            step(8'(1 << c), 32'h87654321, 1'b0);
            chk("skew_valid", 32'(bus.o_valid), 32'(c == COL - 1));
        end
        chk("skew_out",  bus.out,         32'h87654321);
        chk("skew_rows", 32'(bus.o_rows), 32'd1);
        step(8'h00, 32'h0, 1'b1);
        chk("skew_pop_valid", 32'(bus.o_valid), 32'd0);

        // Fill to full, then a dropped write
        for (int i = 0; i < 4; i++) rows[i] = 32'h11111111 * (i + 1);
        for (int i = 0; i < 4; i++) step(8'hFF, rows[i], 1'b0);
        chk("full_full",  32'(bus.o_full),  32'd1);
        chk("full_ready", 32'(bus.o_ready), 32'd0);
        chk("full_rows",  32'(bus.o_rows),  32'd4);
        step(8'hFF, 32'hDEADBEEF, 1'b0);
        chk("ovf_rows", 32'(bus.o_rows), 32'd4);
`ifdef OFIFO_ERR_EN
        chk("ovf_flag", 32'(bus.o_ovf), 32'hFF);
`endif
        for (int i = 0; i < 4; i++) begin
            chk("full_order", bus.out, rows[i]);
            step(8'h00, 32'h0, 1'b1);
        end
        chk("drain_valid", 32'(bus.o_valid), 32'd0);

        // Full with simultaneous write and pop
        for (int i = 0; i < 4; i++) step(8'hFF, rows[i], 1'b0);
        step(8'hFF, 32'hAAAAAAAA, 1'b1);
        chk("fp_full", 32'(bus.o_full), 32'd1);
        chk("fp_rows", 32'(bus.o_rows), 32'd4);
        chk("fp_head", bus.out, rows[1]);
        for (int i = 0; i < 3; i++) step(8'h00, 32'h0, 1'b1);
        chk("fp_out",  bus.out,         32'hAAAAAAAA);
        chk("fp_last", 32'(bus.o_rows), 32'd1);
        step(8'h00, 32'h0, 1'b1);

        // Underflow, then clear flags
        step(8'h00, 32'h0, 1'b1);
        chk("udf_rows",  32'(bus.o_rows),  32'd0);
        chk("udf_valid", 32'(bus.o_valid), 32'd0);
`ifdef OFIFO_ERR_EN
        chk("udf_flag", 32'(bus.o_udf), 32'd1);
`endif
        clr = 1'b1;
        step(8'h00, 32'h0, 1'b0);
        clr = 1'b0;
`ifdef OFIFO_ERR_EN
        chk("clr_udf", 32'(bus.o_udf), 32'd0);
        chk("clr_ovf", 32'(bus.o_ovf), 32'd0);
`endif

        // Interleaved push/pop across pointer wrap
        for (int i = 0; i < 10; i++) v[i] = $urandom;
        step(8'hFF, v[0], 1'b0);
        for (int i = 1; i < 10; i++) begin
            chk("wrap_out", bus.out, v[i-1]);
            step(8'hFF, v[i], 1'b1);
        end
        chk("wrap_last", bus.out, v[9]);
        step(8'h00, 32'h0, 1'b1);

        // Reset mid-stream with 3 rows held
        for (int i = 0; i < 3; i++) step(8'hFF, $urandom, 1'b0);
        chk("mid_rows", 32'(bus.o_rows), 32'd3);
        reset = 1'b1;
        step(8'hFF, 32'h55555555, 1'b1);
        reset = 1'b0;
        chk("mrst_valid", 32'(bus.o_valid), 32'd0);
        chk("mrst_rows",  32'(bus.o_rows),  32'd0);
        chk("mrst_ready", 32'(bus.o_ready), 32'd1);
        step(8'hFF, 32'h13572468, 1'b0);
        chk("mrst_head", bus.out,         32'h13572468);
        chk("mrst_one",  32'(bus.o_rows), 32'd1);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            w = '0;
            for (int c = 0; c < COL; c++) w[c] = ($urandom_range(0, 9) < 6);
            reset = ($urandom_range(0, 199) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            step(w, $urandom, ($urandom_range(0, 9) < 4));
        end
        reset = 1'b0;
        clr   = 1'b0;
        step(8'h00, 32'h0, 1'b0);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
